// File: rtl/code_conv_sched_pkg.sv
// ============================================================================
// Module   : code_conv_sched_pkg
// Purpose  : Shared types and defaults for the code_conv_sched sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package code_conv_sched_pkg;

  localparam int CODE_W            = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_MAX_CODE      = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REJECT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic code_legal(input logic [CODE_W-1:0] code,
                                      input logic [CODE_W-1:0] max_code);
    return (code <= max_code);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-requester round-robin arbiter with combinational grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);

  // Tie-break pointer: 1 means requester 1 wins the next tie. It only
  // toggles when a tie is actually resolved, so a lone request never
  // disturbs the fairness order between contending requesters.
  logic r_prio1;

  assign gnt0 = en & req0 & (~req1 | ~r_prio1);
  assign gnt1 = en & req1 & (~req0 |  r_prio1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio1 <= 1'b0;
    end else if (en && req0 && req1) begin
      r_prio1 <= ~r_prio1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/code_conv_sched.sv
// ============================================================================
// Module   : code_conv_sched
// Purpose  : Arbitrates two requesters onto the shared BCD-to-excess-3
//            converter, waits the settle time and returns the result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_conv_sched
  import code_conv_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_CODE      = DEF_MAX_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [CODE_W-1:0] data0,
  input  logic              req1,
  input  logic [CODE_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic [CODE_W-1:0] result,
  output logic              err,
  output logic              busy,
  output logic [CODE_W-1:0] conv_in,
  input  logic [CODE_W-1:0] conv_out
);

  localparam logic [3:0]        C_CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [CODE_W-1:0] C_MAX_CODE = CODE_W'(MAX_CODE);

  state_t            r_state,   w_state_nxt;
  logic [3:0]        r_cnt,     w_cnt_nxt;
  logic [CODE_W-1:0] r_conv_in, w_conv_in_nxt;
  logic [CODE_W-1:0] r_result,  w_result_nxt;
  logic              r_err,     w_err_nxt;
  logic              r_ack0,    w_ack0_nxt;
  logic              r_ack1,    w_ack1_nxt;
  logic              r_gnt1,    w_gnt1_id_nxt;
  logic              r_busy,    w_busy_nxt;

  logic              w_arb_en;
  logic              w_gnt0;
  logic              w_gnt1;
  logic [CODE_W-1:0] w_sel_data;

  assign w_arb_en   = (r_state == ST_IDLE);
  assign w_sel_data = w_gnt1 ? data1 : data0;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .en   (w_arb_en),
    .gnt0 (w_gnt0),
    .gnt1 (w_gnt1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_conv_in <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_conv_in <= w_conv_in_nxt;
      r_result  <= w_result_nxt;
      r_err     <= w_err_nxt;
      r_ack0    <= w_ack0_nxt;
      r_ack1    <= w_ack1_nxt;
      r_gnt1    <= w_gnt1_id_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_conv_in_nxt = r_conv_in;
    w_result_nxt  = r_result;
    w_err_nxt     = r_err;
    w_gnt1_id_nxt = r_gnt1;
    w_ack0_nxt    = 1'b0;
    w_ack1_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_gnt1_id_nxt = w_gnt1;
          // Illegal codes never reach the converter; conv_in keeps its value.
          if (code_legal(w_sel_data, C_MAX_CODE)) begin
            w_conv_in_nxt = w_sel_data;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_WAIT;
          end else begin
            w_state_nxt   = ST_REJECT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == C_CNT_LAST) begin
          w_result_nxt = conv_out;
          w_err_nxt    = 1'b0;
          w_ack0_nxt   = ~r_gnt1;
          w_ack1_nxt   =  r_gnt1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_cnt_nxt    = r_cnt + 4'd1;
        end
      end
      ST_REJECT: begin
        w_result_nxt = '0;
        w_err_nxt    = 1'b1;
        w_ack0_nxt   = ~r_gnt1;
        w_ack1_nxt   =  r_gnt1;
        w_state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign result  = r_result;
  assign err     = r_err;
  assign busy    = r_busy;
  assign conv_in = r_conv_in;

endmodule

`default_nettype wire

// File: tb/tb_code_conv_sched.sv
// ============================================================================
// Module   : tb_code_conv_sched
// Purpose  : Directed, table-driven bench for code_conv_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_conv_sched;
  import code_conv_sched_pkg::*;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] data0, data1;
  logic       ack0, ack1, err, busy;
  logic [3:0] result, conv_in, conv_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external excess-3 converter.
  assign conv_out = conv_in + 4'd3;

  code_conv_sched #(.SETTLE_CYCLES(S), .MAX_CODE(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .data0    (data0),
    .req1     (req1),
    .data1    (data1),
    .ack0     (ack0),
    .ack1     (ack1),
    .result   (result),
    .err      (err),
    .busy     (busy),
    .conv_in  (conv_in),
    .conv_out (conv_out)
  );

  typedef struct {
    bit         who;
    logic [3:0] data;
    logic [3:0] exp_res;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an ack; lat counts edges from the call.
  task automatic wait_ack(input bit who, input logic [3:0] res, input logic e,
                          input int lat, input logic [3:0] conv);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (n == 1) check("conv_in", 32'(conv_in), 32'(conv));
      if (ack0 || ack1) seen = 1'b1;
    end
    check("ack_seen", 32'(seen), 32'd1);
    check("ack_latency", n, lat);
    check("ack0", 32'(ack0), 32'(who == 1'b0));
    check("ack1", 32'(ack1), 32'(who == 1'b1));
    check("result", 32'(result), 32'(res));
    check("err", 32'(err), 32'(e));
    check("busy_done", 32'(busy), 32'd1);
  endtask

  task automatic end_ack(input bit drop0, input bit drop1);
    if (drop0) req0 = 1'b0;
    if (drop1) req1 = 1'b0;
    tick();
    check("ack0_low", 32'(ack0), 32'd0);
    check("ack1_low", 32'(ack1), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  vec_t       vecs[19];
  logic [3:0] last_conv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].who     = 1'b0;
      vecs[i].data    = 4'(i);
      vecs[i].exp_res = (i <= 9) ? 4'(i + 3) : 4'd0;
      vecs[i].exp_err = (i > 9);
    end
    vecs[16] = '{1'b1, 4'd3,  4'd6,  1'b0};
    vecs[17] = '{1'b1, 4'd12, 4'd0,  1'b1};
    vecs[18] = '{1'b1, 4'd8,  4'd11, 1'b0};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    #12;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_conv_in", 32'(conv_in), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Tie: requester 0 first, then 1; next tie goes to requester 1 first.
    req0 = 1'b1; req1 = 1'b1; data0 = 4'd0; data1 = 4'd9;
    wait_ack(1'b0, 4'd3, 1'b0, S + 1, 4'd0);
    end_ack(1'b1, 1'b0);
    wait_ack(1'b1, 4'd12, 1'b0, S + 1, 4'd9);
    end_ack(1'b0, 1'b1);
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(1'b1, 4'd12, 1'b0, S + 1, 4'd9);
    end_ack(1'b0, 1'b1);
    wait_ack(1'b0, 4'd3, 1'b0, S + 1, 4'd0);
    end_ack(1'b1, 1'b0);
    last_conv = 4'd0;

    for (int i = 0; i < 19; i++) begin
      logic [3:0] exp_conv;
      exp_conv = vecs[i].exp_err ? last_conv : vecs[i].data;
      if (vecs[i].who) begin req1 = 1'b1; data1 = vecs[i].data; end
      else             begin req0 = 1'b1; data0 = vecs[i].data; end
      wait_ack(vecs[i].who, vecs[i].exp_res, vecs[i].exp_err,
               vecs[i].exp_err ? 2 : S + 1, exp_conv);
      end_ack(!vecs[i].who, vecs[i].who);
      if (!vecs[i].exp_err) last_conv = vecs[i].data;
    end

    // Held request: a second transaction follows one idle cycle later.
    req0 = 1'b1; data0 = 4'd5;
    wait_ack(1'b0, 4'd8, 1'b0, S + 1, 4'd5);
    end_ack(1'b0, 1'b0);
    wait_ack(1'b0, 4'd8, 1'b0, S + 1, 4'd5);
    end_ack(1'b1, 1'b0);

    // Asynchronous reset while in WAIT.
    req0 = 1'b1; data0 = 4'd7;
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_conv_in", 32'(conv_in), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_conv_in", 32'(conv_in), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_acks", 32'({ack0, ack1}), 32'd0);
    req0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    req1 = 1'b1; data1 = 4'd3;
    wait_ack(1'b1, 4'd6, 1'b0, S + 1, 4'd3);
    end_ack(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
